// File: rtl/aes_cipher.sv
// Iterative AES-128 encryptor, one round per clock, key schedule expanded on the fly alongside the data.
// Latency: results valid 10 edges after the accepting edge (11 edges including the accept).
// Backpressure: start is ignored while busy; results hold in DONE until the next accepted start.
module aes_cipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         cipher_ready,
  output logic [127:0] cipher_text,
  output logic [127:0] round_key_10
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q;
  logic [127:0] state_q, rk_q;
  logic [7:0]   rcon;
  logic [31:0]  t_word;
  logic [127:0] rk_next, sr, mc, round_out;
  logic         accept, last;

  assign accept = start && (fsm_q != RUN);
  assign last   = (fsm_q == RUN) && (round_q == 4'd10);

  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // SubWord(RotWord(w3)): rotated byte order feeds the four key-schedule S-boxes directly
  assign t_word = {SBOX[rk_q[23:16]], SBOX[rk_q[15:8]], SBOX[rk_q[7:0]], SBOX[rk_q[31:24]]}
                  ^ {rcon, 24'h0};
  assign rk_next[127:96] = rk_q[127:96] ^ t_word;
  assign rk_next[95:64]  = rk_q[95:64]  ^ rk_next[127:96];
  assign rk_next[63:32]  = rk_q[63:32]  ^ rk_next[95:64];
  assign rk_next[31:0]   = rk_q[31:0]   ^ rk_next[63:32];

  // Byte i sits at row i%4, column i/4; ShiftRows takes row r from column (c+r)%4
  always_comb begin
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sr[127-8*i -: 8] = SBOX[state_q[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
  end

  assign round_out = ((round_q == 4'd10) ? sr : mc) ^ rk_next;

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE, DONE: if (start) fsm_d = RUN;
      RUN:        if (round_q == 4'd10) fsm_d = DONE;
      default:    fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q      <= 4'd0;
      state_q      <= '0;
      rk_q         <= '0;
      cipher_text  <= '0;
      round_key_10 <= '0;
      busy         <= 1'b0;
      cipher_ready <= 1'b0;
    end else if (accept) begin
      state_q      <= plain_text ^ cipher_key;
      rk_q         <= cipher_key;
      round_q      <= 4'd1;
      busy         <= 1'b1;
      cipher_ready <= 1'b0;
    end else if (fsm_q == RUN) begin
      state_q <= round_out;
      rk_q    <= rk_next;
      if (last) begin
        round_q      <= 4'd0;
        cipher_text  <= round_out;
        round_key_10 <= rk_next;
        busy         <= 1'b0;
        cipher_ready <= 1'b1;
      end else begin
        round_q <= round_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher: known-answer vectors, protocol corner cases and random blocks
// checked against a GF(2^8)-derived AES model plus a model inverse cipher started from round_key_10.
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] plain_text = '0;
  logic [127:0] cipher_key = '0;
  logic         busy, cipher_ready;
  logic [127:0] cipher_text, round_key_10;

  aes_cipher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plain_text(plain_text), .cipher_key(cipher_key),
    .busy(busy), .cipher_ready(cipher_ready), .cipher_text(cipher_text), .round_key_10(round_key_10)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] rk;
    logic [127:0] pt;
    int           due;
    bit           rt;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: S-box built from GF(2^8) inverse + affine map
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];
  logic [7:0] rcs    [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] y;
      for (int c = 1; c < 256; c++) if (gm(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = y;
    end
    for (int x = 0; x < 256; x++) inv_t[sbox_t[x]] = 8'(x);
    rcs[0] = 8'h00;
    rcs[1] = 8'h01;
    for (int k = 2; k < 11; k++) rcs[k] = xt(rcs[k-1]);
  endtask

  function automatic logic [31:0] g_word(input logic [31:0] w, input int rnd);
    return {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]} ^ {rcs[rnd], 24'h0};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt,
                                             output logic [127:0] rk10);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ ((i % 4 == 0) ? g_word(w[i-1], i / 4) : w[i-1]);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
          s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    rk10 = {w[40], w[41], w[42], w[43]};
    return out;
  endfunction

  // Inverse cipher seeded only by the final round key, run the schedule backwards
  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] rk10);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[40+i] = rk10[127-32*i -: 32];
    for (int i = 39; i >= 0; i--)
      w[i] = w[i+4] ^ (((i + 4) % 4 == 0) ? g_word(w[i+3], (i + 4) / 4) : w[i+3]);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) t[i] = inv_t[s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) t[k] = s[4*c+k];
          s[4*c]   = gm(t[0], 14) ^ gm(t[1], 11) ^ gm(t[2], 13) ^ gm(t[3], 9);
          s[4*c+1] = gm(t[0], 9)  ^ gm(t[1], 14) ^ gm(t[2], 11) ^ gm(t[3], 13);
          s[4*c+2] = gm(t[0], 13) ^ gm(t[1], 9)  ^ gm(t[2], 14) ^ gm(t[3], 11);
          s[4*c+3] = gm(t[0], 11) ^ gm(t[1], 13) ^ gm(t[2], 9)  ^ gm(t[3], 14);
        end
      end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- monitor: pop one expectation per rising cipher_ready
  bit prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (cipher_ready && !prev_rdy) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready got=1 want=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("cipher_text", cipher_text, e.ct);
          chk("round_key_10", round_key_10, e.rk);
          chk("ready_cycle", 128'(cyc), 128'(e.due));
          if (e.rt) chk("round_trip_pt", model_dec(cipher_text, round_key_10), e.pt);
        end
      end
      prev_rdy = cipher_ready;
    end
  end

  // ---------------- stimulus helpers (entered and left on a falling edge)
  task automatic push_exp(input logic [127:0] ct, input logic [127:0] rk, input logic [127:0] pt,
                          input int due, input bit rt);
    exp_t e;
    e.ct = ct; e.rk = rk; e.pt = pt; e.due = due; e.rt = rt;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [127:0] key, input logic [127:0] pt);
    plain_text = pt;
    cipher_key = key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("idle_timeout", 128'(n >= 100), 128'(0));
  endtask

  initial begin
    logic [127:0] k, p, ct, rk;
    bit saw_rdy;
    build_tables();

    repeat (3) @(negedge clk);
    chk("rst_cipher_text", cipher_text, '0);
    chk("rst_round_key_10", round_key_10, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(cipher_ready), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // App B and App C.1 known answers
    push_exp(CT_B, RK_B, PT_B, cyc + 11, 1'b1);
    issue(KEY_B, PT_B);
    wait_idle();
    push_exp(CT_C, RK_C, PT_C, cyc + 11, 1'b1);
    issue(KEY_C, PT_C);
    wait_idle();

    // start during RUN is ignored; busy holds through E9
    push_exp(CT_B, RK_B, PT_B, cyc + 11, 1'b0);
    issue(KEY_B, PT_B);
    for (int j = 0; j < 10; j++) begin
      chk("busy_in_run", 128'(busy), 128'(1));
      if (j == 3) begin
        plain_text = PT_C;
        cipher_key = KEY_C;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();

    // back-to-back with start held high
    begin
      int k0;
      k0 = cyc;
      push_exp(CT_B, RK_B, PT_B, k0 + 11, 1'b0);
      push_exp(CT_C, RK_C, PT_C, k0 + 22, 1'b0);
      plain_text = PT_B;
      cipher_key = KEY_B;
      start = 1'b1;
      @(negedge clk);
      plain_text = PT_C;
      cipher_key = KEY_C;
      repeat (10) @(negedge clk);
      chk("b2b_first_ready", 128'(cipher_ready), 128'(1));
      @(negedge clk);
      chk("b2b_ready_dropped", 128'(cipher_ready), 128'(0));
      start = 1'b0;
      saw_rdy = 1'b0;
      for (int j = 0; j < 9; j++) begin
        @(negedge clk);
        if (cipher_ready) saw_rdy = 1'b1;
      end
      chk("b2b_ready_low_in_run", 128'(saw_rdy), 128'(0));
      wait_idle();
    end

    // reset in the middle of a run
    issue(KEY_B, PT_B);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cipher_text", cipher_text, '0);
    chk("midrst_round_key_10", round_key_10, '0);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_ready", 128'(cipher_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_rdy = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (cipher_ready || busy) saw_rdy = 1'b1;
    end
    chk("post_rst_quiet", 128'(saw_rdy), 128'(0));
    push_exp(CT_B, RK_B, PT_B, cyc + 11, 1'b1);
    issue(KEY_B, PT_B);
    wait_idle();

    // random blocks against the model, with round trip through the inverse model
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      ct = model_enc(k, p, rk);
      push_exp(ct, rk, p, cyc + 11, 1'b1);
      issue(k, p);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
